// File: rtl/bitstream_serializer_if.sv
// Word-source and SMU-stream signals of the bitstream serializer.
// The serializer takes the slave view; the word source / SMU side takes the master view.
interface bitstream_serializer_if #(
  parameter int unsigned WORD_W = 8
);
  logic [WORD_W-1:0] WordIn;
  logic              WordValid;
  logic              WordReady;
  logic              SerialOut;
  logic              StreamValid;
  logic              LoadedIn;

  modport master (
    output WordIn, WordValid, LoadedIn,
    input  WordReady, SerialOut, StreamValid
  );

  modport slave (
    input  WordIn, WordValid, LoadedIn,
    output WordReady, SerialOut, StreamValid
  );
endinterface

// File: rtl/bitstream_serializer.sv
// Serializes CFG_SIZE configuration bits, fetched WORD_W at a time, LSB first, then
// waits up to TIMEOUT cycles for the SMU load acknowledge.
module bitstream_serializer #(
  parameter int unsigned CFG_SIZE = 64,
  parameter int unsigned WORD_W   = 8,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         Start,
  input  logic                         Abort,
  bitstream_serializer_if.slave        bus,
  output logic                         Busy,
  output logic                         Done,
  output logic                         Error
);
  localparam int unsigned BitCntW  = $clog2(CFG_SIZE + 1);
  localparam int unsigned WordCntW = $clog2(WORD_W + 1);
  localparam int unsigned TimerW   = $clog2(TIMEOUT + 1);

  localparam logic [BitCntW-1:0]  LastBit     = BitCntW'(CFG_SIZE - 1);
  localparam logic [WordCntW-1:0] LastWordBit = WordCntW'(WORD_W - 1);
  localparam logic [TimerW-1:0]   LastTick    = TimerW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StShift,
    StWaitAck,
    StDone,
    StError
  } state_e;

  state_e              state;
  logic [WORD_W-1:0]   shiftReg;
  logic [BitCntW-1:0]  bitCnt;
  logic [WordCntW-1:0] wordCnt;
  logic [TimerW-1:0]   timer;
  logic                inXfer;

  assign inXfer = (state == StFetch) || (state == StShift) || (state == StWaitAck);

  // Outputs are registered: each transition sets the values the next state presents.
  // SerialOut/StreamValid carry the bit for the cycle after the edge, so the word's
  // bit 0 is loaded straight into SerialOut on acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= StIdle;
      shiftReg        <= '0;
      bitCnt          <= '0;
      wordCnt         <= '0;
      timer           <= '0;
      bus.WordReady   <= 1'b0;
      bus.SerialOut   <= 1'b0;
      bus.StreamValid <= 1'b0;
      Busy            <= 1'b0;
      Done            <= 1'b0;
      Error           <= 1'b0;
    end else begin
      bus.WordReady   <= 1'b0;
      bus.SerialOut   <= 1'b0;
      bus.StreamValid <= 1'b0;
      if (Abort && inXfer) begin
        state   <= StIdle;
        bitCnt  <= '0;
        wordCnt <= '0;
        timer   <= '0;
        Busy    <= 1'b0;
      end else begin
        unique case (state)
          StIdle, StDone, StError: begin
            if (Start) begin
              state         <= StFetch;
              bitCnt        <= '0;
              timer         <= '0;
              Done          <= 1'b0;
              Error         <= 1'b0;
              Busy          <= 1'b1;
              bus.WordReady <= 1'b1;
            end
          end
          StFetch: begin
            if (bus.WordValid) begin
              state           <= StShift;
              shiftReg        <= bus.WordIn >> 1;
              wordCnt         <= '0;
              bus.SerialOut   <= bus.WordIn[0];
              bus.StreamValid <= 1'b1;
            end else begin
              bus.WordReady <= 1'b1;
            end
          end
          StShift: begin
            // bitCnt/wordCnt index the bit on SerialOut during this cycle.
            bitCnt <= bitCnt + 1'b1;
            if (bitCnt == LastBit) begin
              state <= StWaitAck;
              timer <= '0;
            end else if (wordCnt == LastWordBit) begin
              state         <= StFetch;
              bus.WordReady <= 1'b1;
            end else begin
              wordCnt         <= wordCnt + 1'b1;
              shiftReg        <= shiftReg >> 1;
              bus.SerialOut   <= shiftReg[0];
              bus.StreamValid <= 1'b1;
            end
          end
          StWaitAck: begin
            timer <= timer + 1'b1;
            if (bus.LoadedIn) begin
              state <= StDone;
              Done  <= 1'b1;
              Busy  <= 1'b0;
            end else if (timer == LastTick) begin
              state <= StError;
              Error <= 1'b1;
              Busy  <= 1'b0;
            end
          end
          default: begin
            state <= StIdle;
            Busy  <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule
